msg_reader: RTL and testbench
=============================

MSG_READER -- requirements
Module: msg_reader

Interface
REQ-001 The block SHALL have parameter POLL_INTERVAL, default 1024, giving the idle cycles between status polls when too few words are buffered.
REQ-002 The block SHALL have parameter MSG_ID, default 32'h00524242, the bounding-box message ID word ("RBB", zero-padded).
REQ-003 clk  input  1  the single clock; all state changes on rising edge.
REQ-004 reset_n  input  1  reset, synchronous and active-low.
REQ-005 enable  input  1  high = run the poll/read loop; low = finish the current message, then idle.
REQ-006 m_chipselect  output  1  MM master select to the image-processor slave.
REQ-007 m_read  output  1  MM read strobe.
REQ-008 m_write  output  1  MM write strobe.
REQ-009 m_address  output  4  word address: 0 = status, 1 = message FIFO.
REQ-010 m_writedata  output  32  write data.
REQ-011 m_readdata  input  32  read data, valid exactly 1 cycle after the m_read cycle.
REQ-012 bb_left, bb_top, bb_right, bb_bottom  output  11 each  last decoded box.
REQ-013 bb_valid  output  1  one-cycle pulse per decoded message.
REQ-014 bb_empty  output  1  last decoded message reported no detection.
REQ-015 msg_count  output  16  decoded messages, wrapping.
REQ-016 resync_count  output  8  discarded non-ID words, saturating at 255.

Function
REQ-017 Bus access: each read or write SHALL hold m_chipselect together with its strobe for exactly 1 cycle, with m_read and m_write never both high.
REQ-018 Every bus access SHALL be followed by at least 1 idle cycle with all strobes low, so the slave's FIFO-pop edge detect re-arms.
REQ-019 States SHALL be: FLUSH, POLL, POLL_CAP, WAIT, ID_RD, ID_CAP, TL_RD, TL_CAP, BR_RD, BR_CAP, GAP, IDLE.
REQ-020 After reset with enable=1, FLUSH SHALL issue one write to address 0 with data 32'h00000010, then go to POLL.
REQ-021 If enable=0 after reset, the block SHALL stay in IDLE; an enable rise from IDLE SHALL enter FLUSH.
REQ-022 POLL SHALL read address 0; POLL_CAP SHALL take cnt = m_readdata[15:8].
REQ-023 If cnt >= 3, the next read SHALL be ID_RD.
REQ-024 If cnt < 3, the block SHALL go to WAIT for POLL_INTERVAL cycles (counter loaded with POLL_INTERVAL-1, down to 0), then POLL.
REQ-025 ID_RD, TL_RD and BR_RD SHALL each read address 1 and be separated by GAP cycles.
REQ-026 ID_CAP match (m_readdata == MSG_ID) SHALL proceed to TL_RD.
REQ-027 ID_CAP mismatch SHALL increment resync_count (saturating), generate no bb_valid, and go GAP then POLL.
REQ-028 TL_CAP SHALL hold x = m_readdata[26:16] and y = m_readdata[10:0]; bits 31:27 and 15:11 are ignored.
REQ-029 BR_CAP SHALL hold x = m_readdata[26:16] and y = m_readdata[10:0], with the same bits ignored.
REQ-030 In the cycle after BR_CAP, bb_valid SHALL be 1 for exactly 1 cycle and msg_count SHALL increment.
REQ-031 Empty box (TL x > BR x, or TL y > BR y): bb_empty SHALL be 1 and bb_* SHALL hold their previous values.
REQ-032 Otherwise bb_empty SHALL be 0 and bb_left/top/right/bottom SHALL take TL x, TL y, BR x, BR y, changing in the same cycle bb_valid is high.
REQ-033 After a message the block SHALL go GAP then POLL if enable=1, else IDLE.
REQ-034 enable falling mid-message SHALL not abort the message.
REQ-035 Simultaneous msg_count wrap (65535 to 0) and bb_valid SHALL be legal.

Reset
REQ-036 With reset_n low at a clock edge, all outputs SHALL be 0 on the next cycle: strobes, m_address, m_writedata, bb_*, bb_valid, bb_empty, msg_count, resync_count.
REQ-037 Reset SHALL override any in-flight state, including mid-read, mid-message and during WAIT; the captured TL coordinate is discarded.

Verification
REQ-038 Reset, enable=1 -> first access: write, addr 0, data 0x00000010, single cycle, then 1 idle cycle, then read addr 0.
REQ-039 Status 0x00000200 -> no addr-1 read; next status read exactly POLL_INTERVAL cycles after POLL_CAP plus the POLL issue cycle.
REQ-040 Status 0x00000300, reads 0x00524242, 0x00640032, 0x00C80096 -> bb_left=100, bb_top=50, bb_right=200, bb_bottom=150, bb_valid 1 cycle, bb_empty=0, msg_count=1.
REQ-041 Status 0x00000300, first FIFO word 0xDEADBEEF -> resync_count=1, no bb_valid, next access is a status read.
REQ-042 Message 0x00524242, 0x027F01DF, 0x00000000 -> bb_valid=1, bb_empty=1, bb_* unchanged.
REQ-043 reset_n low in TL_CAP -> all outputs 0 next cycle; after release, FLUSH write is the first access and no bb_valid occurs for the aborted message.

Source files
------------

// File: rtl/msg_reader_if.sv
// Memory-mapped bus between the message reader (master) and the image-processor slave.
interface msg_reader_if;
  logic        m_chipselect;
  logic        m_read;
  logic        m_write;
  logic [3:0]  m_address;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;

  modport master (output m_chipselect, m_read, m_write, m_address, m_writedata,
                  input  m_readdata);
  modport slave  (input  m_chipselect, m_read, m_write, m_address, m_writedata,
                  output m_readdata);
endinterface

// File: rtl/msg_reader.sv
// Polls the image-processor status word and decodes three-word bounding-box
// messages (ID, top-left, bottom-right) from its message FIFO.
module msg_reader #(
  parameter int          POLL_INTERVAL = 1024,
  parameter logic [31:0] MSG_ID        = 32'h00524242
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         enable,
  msg_reader_if.master m,
  output logic [10:0]  bb_left,
  output logic [10:0]  bb_top,
  output logic [10:0]  bb_right,
  output logic [10:0]  bb_bottom,
  output logic         bb_valid,
  output logic         bb_empty,
  output logic [15:0]  msg_count,
  output logic [7:0]   resync_count
);
  typedef enum logic [3:0] {
    FLUSH, POLL, POLL_CAP, WAIT, ID_RD, ID_CAP,
    TL_RD, TL_CAP, BR_RD, BR_CAP, GAP, IDLE
  } state_t;

  state_t      state, nxt;
  logic [31:0] wait_cnt;
  logic [10:0] tl_x, tl_y, br_x, br_y;
  logic        id_match, cnt_ok;

  assign br_x     = m.m_readdata[26:16];
  assign br_y     = m.m_readdata[10:0];
  assign id_match = (m.m_readdata == MSG_ID);
  assign cnt_ok   = (m.m_readdata[15:8] >= 8'd3);

  // Bus strobes are a pure decode of state; every access state is followed
  // by a non-access state, which gives the slave its re-arm idle cycle.
  always_comb begin
    nxt            = state;
    m.m_chipselect = 1'b0;
    m.m_read       = 1'b0;
    m.m_write      = 1'b0;
    m.m_address    = 4'd0;
    m.m_writedata  = 32'd0;
    case (state)
      IDLE:     if (enable) nxt = FLUSH;
      FLUSH: begin
        m.m_chipselect = 1'b1;
        m.m_write      = 1'b1;
        m.m_writedata  = 32'h0000_0010;
        nxt            = GAP;
      end
      POLL: begin
        m.m_chipselect = 1'b1;
        m.m_read       = 1'b1;
        nxt            = POLL_CAP;
      end
      POLL_CAP: nxt = !enable ? IDLE : (cnt_ok ? ID_RD : WAIT);
      WAIT:     if (wait_cnt == 32'd0) nxt = enable ? POLL : IDLE;
      ID_RD, TL_RD, BR_RD: begin
        m.m_chipselect = 1'b1;
        m.m_read       = 1'b1;
        m.m_address    = 4'd1;
        nxt            = (state == ID_RD) ? ID_CAP : (state == TL_RD) ? TL_CAP : BR_CAP;
      end
      ID_CAP:   nxt = id_match ? TL_RD : GAP;
      TL_CAP:   nxt = BR_RD;
      BR_CAP:   nxt = GAP;
      GAP:      nxt = enable ? POLL : IDLE;
      default:  nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      wait_cnt     <= 32'd0;
      tl_x         <= 11'd0;
      tl_y         <= 11'd0;
      bb_left      <= 11'd0;
      bb_top       <= 11'd0;
      bb_right     <= 11'd0;
      bb_bottom    <= 11'd0;
      bb_valid     <= 1'b0;
      bb_empty     <= 1'b0;
      msg_count    <= 16'd0;
      resync_count <= 8'd0;
    end else begin
      state    <= nxt;
      bb_valid <= 1'b0;
      if (state == POLL_CAP)
        wait_cnt <= 32'(POLL_INTERVAL - 1);
      else if (state == WAIT && wait_cnt != 32'd0)
        wait_cnt <= wait_cnt - 32'd1;
      if (state == ID_CAP && !id_match && resync_count != 8'hFF)
        resync_count <= resync_count + 8'd1;
      if (state == TL_CAP) begin
        tl_x <= m.m_readdata[26:16];
        tl_y <= m.m_readdata[10:0];
      end
      // An inverted box means "no detection": flag it, keep the last good box.
      if (state == BR_CAP) begin
        bb_valid  <= 1'b1;
        msg_count <= msg_count + 16'd1;
        if (tl_x > br_x || tl_y > br_y) begin
          bb_empty <= 1'b1;
        end else begin
          bb_empty  <= 1'b0;
          bb_left   <= tl_x;
          bb_top    <= tl_y;
          bb_right  <= br_x;
          bb_bottom <= br_y;
        end
      end
    end
  end
endmodule

// File: tb/tb_msg_reader.sv
// Bench for msg_reader: FIFO/status slave model, bus protocol monitor and a
// message-level reference model driven by directed and random messages.
module tb_msg_reader;
  localparam int          P  = 8;
  localparam logic [31:0] ID = 32'h00524242;

  logic        clk = 1'b0, reset_n = 1'b0, enable = 1'b0;
  logic [10:0] bb_left, bb_top, bb_right, bb_bottom;
  logic        bb_valid, bb_empty;
  logic [15:0] msg_count;
  logic [7:0]  resync_count;

  msg_reader_if bus();

  msg_reader #(.POLL_INTERVAL(P), .MSG_ID(ID)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .m(bus),
    .bb_left(bb_left), .bb_top(bb_top), .bb_right(bb_right), .bb_bottom(bb_bottom),
    .bb_valid(bb_valid), .bb_empty(bb_empty),
    .msg_count(msg_count), .resync_count(resync_count)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; bit wr; logic [3:0] addr; logic [31:0] data; } acc_t;
  acc_t        acc_q[$];
  logic [31:0] fifo[$];
  int checks = 0, failures = 0, cyc = 0, vcount = 0, rd1 = 0;
  bit prev_acc = 1'b0, acc_now;
  int exp_l = 0, exp_t = 0, exp_r = 0, exp_b = 0, exp_e = 0, exp_cnt = 0, exp_rs = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Slave: status reports FIFO depth in [15:8]; data appears the cycle after the read.
  always @(posedge clk) begin
    if (bus.m_chipselect && bus.m_read) begin
      if (bus.m_address == 4'd0)    bus.m_readdata <= {16'h0, 8'(fifo.size()), 8'h0};
      else if (fifo.size() > 0)     bus.m_readdata <= fifo.pop_front();
      else                          bus.m_readdata <= 32'h0;
    end else begin
      bus.m_readdata <= $urandom();
    end
  end

  always @(negedge clk) begin
    cyc++;
    acc_now = bus.m_read || bus.m_write;
    chk("rd_and_wr", bus.m_read && bus.m_write, 0);
    chk("cs_with_strobe", bus.m_chipselect, acc_now);
    if (prev_acc) chk("idle_after_access", acc_now, 0);
    prev_acc = acc_now;
    if (acc_now) acc_q.push_back('{cyc, bus.m_write, bus.m_address, bus.m_writedata});
    if (bus.m_read && bus.m_address == 4'd1) rd1++;
    if (bb_valid) vcount++;
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic wait_acc(int n);
    for (int i = 0; i < 300 && acc_q.size() < n; i++) step();
    if (acc_q.size() < n) chk("timeout_access", 0, 1);
  endtask

  task automatic chk_outputs(string tag);
    chk({tag, "_left"},   bb_left,      exp_l);
    chk({tag, "_top"},    bb_top,       exp_t);
    chk({tag, "_right"},  bb_right,     exp_r);
    chk({tag, "_bottom"}, bb_bottom,    exp_b);
    chk({tag, "_empty"},  bb_empty,     exp_e);
    chk({tag, "_count"},  msg_count,    exp_cnt);
    chk({tag, "_resync"}, resync_count, exp_rs);
  endtask

  task automatic chk_reset_zero();
    chk("rst_cs",    bus.m_chipselect, 0);
    chk("rst_rd",    bus.m_read, 0);
    chk("rst_wr",    bus.m_write, 0);
    chk("rst_addr",  bus.m_address, 0);
    chk("rst_wdata", bus.m_writedata, 0);
    chk("rst_valid", bb_valid, 0);
    exp_l = 0; exp_t = 0; exp_r = 0; exp_b = 0; exp_e = 0; exp_cnt = 0; exp_rs = 0;
    chk_outputs("rst");
  endtask

  // Model: a message decodes to x=[26:16], y=[10:0]; an inverted box only sets empty.
  task automatic run_msg(bit garb, logic [31:0] tl, logic [31:0] br, bit drop_en);
    int v0, r0, tx, ty, bx, by;
    bit got;
    logic [31:0] g;
    v0 = vcount; r0 = rd1;
    if (garb) begin
      do g = $urandom(); while (g == ID);
      fifo.push_back(g);
      exp_rs = (exp_rs == 255) ? 255 : exp_rs + 1;
    end
    fifo.push_back(ID); fifo.push_back(tl); fifo.push_back(br);
    tx = (tl >> 16) % 2048; ty = tl % 2048;
    bx = (br >> 16) % 2048; by = br % 2048;
    if (tx > bx || ty > by) exp_e = 1;
    else begin exp_e = 0; exp_l = tx; exp_t = ty; exp_r = bx; exp_b = by; end
    exp_cnt = (exp_cnt + 1) % 65536;
    if (drop_en) begin
      for (int i = 0; i < 300 && rd1 <= r0 + int'(garb); i++) step();
      enable = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin step(); got = (vcount > v0); end
    chk("valid_seen", got, 1);
    if (got) begin
      chk("valid_high", bb_valid, 1);
      chk_outputs("msg");
      step();
      chk("valid_one_cycle", bb_valid, 0);
    end
  endtask

  function automatic logic [31:0] coord(int x, int y);
    logic [4:0] j1, j2;
    j1 = 5'($urandom()); j2 = 5'($urandom());
    return {j1, 11'(x), j2, 11'(y)};
  endfunction

  initial begin
    int n, v0, i1, x0, x1, y0, y1, t;
    bit got;
    reset_n = 1'b0; enable = 1'b1;
    step(); step();
    chk_reset_zero();

    // Two buffered words: status 0x200, so no FIFO read, just a re-poll.
    fifo.push_back(32'hAAAA_AAAA); fifo.push_back(32'hBBBB_BBBB);
    reset_n = 1'b1;
    wait_acc(1);
    if (acc_q.size() >= 1) begin
      chk("flush_wr",   acc_q[0].wr, 1);
      chk("flush_addr", acc_q[0].addr, 0);
      chk("flush_data", acc_q[0].data, 32'h10);
    end
    wait_acc(3);
    if (acc_q.size() >= 3) begin
      chk("poll_after_flush", acc_q[1].cyc - acc_q[0].cyc, 2);
      chk("poll_is_read",     {acc_q[1].wr, acc_q[1].addr}, 0);
      chk("poll_interval",    acc_q[2].cyc - acc_q[1].cyc, P + 2);
      chk("repoll_addr",      {acc_q[2].wr, acc_q[2].addr}, 0);
    end
    chk("no_fifo_read", rd1, 0);
    fifo.delete();

    run_msg(1'b0, 32'h0064_0032, 32'h00C8_0096, 1'b0);
    chk("box_left", bb_left, 100);
    chk("box_bottom", bb_bottom, 150);

    // Non-ID word: resync, then straight back to a status read.
    v0 = vcount;
    fifo.push_back(32'hDEAD_BEEF); fifo.push_back(32'h1111_1111); fifo.push_back(32'h2222_2222);
    for (int i = 0; i < 300 && resync_count == 8'd0; i++) step();
    chk("resync_one", resync_count, 1);
    exp_rs = 1;
    i1 = acc_q.size() - 1;
    chk("resync_last_rd1", acc_q[i1].addr, 1);
    wait_acc(i1 + 2);
    if (acc_q.size() >= i1 + 2) chk("resync_next_status", {acc_q[i1 + 1].wr, acc_q[i1 + 1].addr}, 0);
    chk("resync_no_valid", vcount, v0);
    chk("resync_count_kept", msg_count, 1);
    fifo.delete();

    run_msg(1'b0, 32'h027F_01DF, 32'h0, 1'b0);

    // Enable drops after the ID read: message completes, then block idles.
    run_msg(1'b1, coord(10, 20), coord(30, 40), 1'b1);
    n = acc_q.size();
    repeat (20) step();
    chk("idle_no_access", acc_q.size(), n);
    enable = 1'b1;
    wait_acc(n + 1);
    if (acc_q.size() >= n + 1) chk("reflush", {acc_q[n].wr, acc_q[n].data}, {1'b1, 32'h10});

    for (int k = 0; k < 16; k++) begin
      x0 = $urandom_range(0, 2047); x1 = $urandom_range(0, 2047);
      y0 = $urandom_range(0, 2047); y1 = $urandom_range(0, 2047);
      if (x0 > x1) begin t = x0; x0 = x1; x1 = t; end
      if (y0 > y1) begin t = y0; y0 = y1; y1 = t; end
      if ($urandom_range(0, 3) == 0) begin t = x0; x0 = x1; x1 = t; end
      run_msg($urandom_range(0, 2) == 0, coord(x0, y0), coord(x1, y1), 1'b0);
    end

    // Reset asserted during TL_CAP aborts the message.
    fifo.push_back(ID); fifo.push_back(coord(1, 2)); fifo.push_back(coord(3, 4));
    n = rd1;
    for (int i = 0; i < 300 && rd1 < n + 2; i++) step();
    chk("reached_tl_rd", rd1, n + 2);
    step();
    reset_n = 1'b0;
    step();
    chk_reset_zero();
    step();
    fifo.delete();
    n = acc_q.size(); v0 = vcount;
    reset_n = 1'b1;
    wait_acc(n + 1);
    if (acc_q.size() >= n + 1) chk("post_rst_flush", {acc_q[n].wr, acc_q[n].addr, acc_q[n].data}, {1'b1, 4'd0, 32'h10});
    repeat (30) step();
    chk("aborted_no_valid", vcount, v0);
    chk_outputs("post_rst");

    run_msg(1'b0, coord(5, 6), coord(7, 8), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
